// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and its ALU decoder.
// Optional feature macro: MULTICYCLE_ADDI_EN (adds the ADDIEX/ADDIWB path).
package mips_pkg;

    // Controller states; ADDI states exist only when the ADDI path is built
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
`ifdef MULTICYCLE_ADDI_EN
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11,
`endif
        ST_JUMP    = 4'd9
    } state_t;

    // Opcode field instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU decoder requests
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // State-derived datapath control vector
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       branch;
        logic       pc_write;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        alu_op: 2'b00, alu_src_a: 1'b0, alu_src_b: 2'b00, pc_src: 2'b00,
        iord: 1'b0, ir_write: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
        reg_dst: 1'b0, mem_to_reg: 1'b0, branch: 1'b0, pc_write: 1'b0
    };

    // True for opcodes the controller executes; ADDI only when its path is built
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI:                              legal = 1'b1;
`endif
            default:                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake between the multicycle datapath (master) and its controller (slave).
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_write;
    logic       pc_en;
    logic       illegal_op;

    modport master (
        output opcode, zero,
        input  alu_op, alu_src_a, alu_src_b, pc_src, iord, ir_write, mem_write,
               reg_write, reg_dst, mem_to_reg, branch, pc_write, pc_en, illegal_op
    );

    modport slave (
        input  opcode, zero,
        output alu_op, alu_src_a, alu_src_b, pc_src, iord, ir_write, mem_write,
               reg_write, reg_dst, mem_to_reg, branch, pc_write, pc_en, illegal_op
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: maps the controller state to the datapath control vector.
// Optional feature macro: MULTICYCLE_ADDI_EN.
module mc_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    // Per-state control assertions; anything not listed stays deasserted
    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM4;
            end
            ST_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                ctrl_o.iord = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.branch    = 1'b1;
            end
`ifdef MULTICYCLE_ADDI_EN
            ST_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            ST_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
`endif
            ST_JUMP: begin
                ctrl_o.pc_src   = PCSRC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
            default: begin
                ctrl_o = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: state register and next-state logic;
// outputs are decoded from the state alone except pc_en and illegal_op.
// Optional feature macro: MULTICYCLE_ADDI_EN (ADDI executes instead of trapping as illegal).
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_if.slave      bus
);

    state_t state_q;
    ctrl_t  ctrl_s;

    // Instruction sequencing; reset aborts any instruction back to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH:   state_q <= ST_DECODE;
                ST_DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state_q <= ST_MEMADR;
                        OP_RTYPE:     state_q <= ST_EXECUTE;
                        OP_BEQ:       state_q <= ST_BRANCH;
`ifdef MULTICYCLE_ADDI_EN
                        OP_ADDI:      state_q <= ST_ADDIEX;
`endif
                        OP_J:         state_q <= ST_JUMP;
                        default:      state_q <= ST_FETCH;
                    endcase
                end
                ST_MEMADR: begin
                    // Opcode is held stable from DECODE, so the final else is a safety net
                    if (bus.opcode == OP_LW) begin
                        state_q <= ST_MEMRD;
                    end else if (bus.opcode == OP_SW) begin
                        state_q <= ST_MEMWR;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_MEMRD:   state_q <= ST_MEMWB;
                ST_EXECUTE: state_q <= ST_ALUWB;
`ifdef MULTICYCLE_ADDI_EN
                ST_ADDIEX:  state_q <= ST_ADDIWB;
                ST_ADDIWB:  state_q <= ST_FETCH;
`endif
                ST_MEMWB:   state_q <= ST_FETCH;
                ST_MEMWR:   state_q <= ST_FETCH;
                ST_ALUWB:   state_q <= ST_FETCH;
                ST_BRANCH:  state_q <= ST_FETCH;
                ST_JUMP:    state_q <= ST_FETCH;
                default:    state_q <= ST_FETCH;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl_s)
    );

    assign bus.alu_op     = ctrl_s.alu_op;
    assign bus.alu_src_a  = ctrl_s.alu_src_a;
    assign bus.alu_src_b  = ctrl_s.alu_src_b;
    assign bus.pc_src     = ctrl_s.pc_src;
    assign bus.iord       = ctrl_s.iord;
    assign bus.ir_write   = ctrl_s.ir_write;
    assign bus.mem_write  = ctrl_s.mem_write;
    assign bus.reg_write  = ctrl_s.reg_write;
    assign bus.reg_dst    = ctrl_s.reg_dst;
    assign bus.mem_to_reg = ctrl_s.mem_to_reg;
    assign bus.branch     = ctrl_s.branch;
    assign bus.pc_write   = ctrl_s.pc_write;

    // Branch is taken in the BRANCH cycle itself using the live zero flag
    assign bus.pc_en      = ctrl_s.pc_write | (ctrl_s.branch & bus.zero);
    assign bus.illegal_op = (state_q == ST_DECODE) && !op_is_legal(bus.opcode);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle control vectors for each
// instruction class, plus reset-release and mid-instruction reset sequences.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       a;
        logic [1:0] b;
        logic [1:0] pcs;
        logic       iord;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       regdst;
        logic       m2r;
        logic       br;
        logic       pcw;
        logic       pcen;
        logic       ill;
    } obs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       zero;
        int         len;
        obs_t [4:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [1:0] aop, input logic a, input logic [1:0] b,
                                input logic [1:0] pcs, input logic [9:0] f);
        obs_t o;
        o.alu_op = aop; o.a = a; o.b = b; o.pcs = pcs;
        {o.iord, o.irw, o.memw, o.regw, o.regdst, o.m2r, o.br, o.pcw, o.pcen, o.ill} = f;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.alu_op = bus_if.alu_op;   o.a = bus_if.alu_src_a;
        o.b = bus_if.alu_src_b;     o.pcs = bus_if.pc_src;
        o.iord = bus_if.iord;       o.irw = bus_if.ir_write;
        o.memw = bus_if.mem_write;  o.regw = bus_if.reg_write;
        o.regdst = bus_if.reg_dst;  o.m2r = bus_if.mem_to_reg;
        o.br = bus_if.branch;       o.pcw = bus_if.pc_write;
        o.pcen = bus_if.pc_en;      o.ill = bus_if.illegal_op;
        return o;
    endfunction

    task automatic check(input string nm, input obs_t exp);
        obs_t act;
        act = sample();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %05h expected %05h", nm, act, exp);
        end
    endtask

    // Expected vectors per state; flag order iord,irw,memw,regw,regdst,m2r,br,pcw,pcen,ill
    obs_t S_F, S_D, S_DILL, S_MA, S_MR, S_MWB, S_MW, S_EX, S_AWB, S_BR1, S_BR0, S_AE, S_AW, S_J;
    vec_t vecs[$];

    task automatic add(input string nm, input logic [5:0] op, input logic z, input int len,
                       input obs_t e0, input obs_t e1, input obs_t e2, input obs_t e3, input obs_t e4);
        vec_t v;
        v.name = nm; v.op = op; v.zero = z; v.len = len;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        vecs.push_back(v);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        S_F    = mk(2'b00, 1'b0, 2'b01, 2'b00, 10'b0100000110);
        S_D    = mk(2'b00, 1'b0, 2'b11, 2'b00, 10'b0000000000);
        S_DILL = mk(2'b00, 1'b0, 2'b11, 2'b00, 10'b0000000001);
        S_MA   = mk(2'b00, 1'b1, 2'b10, 2'b00, 10'b0000000000);
        S_MR   = mk(2'b00, 1'b0, 2'b00, 2'b00, 10'b1000000000);
        S_MWB  = mk(2'b00, 1'b0, 2'b00, 2'b00, 10'b0001010000);
        S_MW   = mk(2'b00, 1'b0, 2'b00, 2'b00, 10'b1010000000);
        S_EX   = mk(2'b10, 1'b1, 2'b00, 2'b00, 10'b0000000000);
        S_AWB  = mk(2'b00, 1'b0, 2'b00, 2'b00, 10'b0001100000);
        S_BR1  = mk(2'b01, 1'b1, 2'b00, 2'b01, 10'b0000001010);
        S_BR0  = mk(2'b01, 1'b1, 2'b00, 2'b01, 10'b0000001000);
        S_AE   = mk(2'b00, 1'b1, 2'b10, 2'b00, 10'b0000000000);
        S_AW   = mk(2'b00, 1'b0, 2'b00, 2'b00, 10'b0001000000);
        S_J    = mk(2'b00, 1'b0, 2'b00, 2'b10, 10'b0000000110);

        add("lw",     6'b100011, 1'b0, 5, S_F, S_D, S_MA, S_MR, S_MWB);
        add("sw",     6'b101011, 1'b1, 4, S_F, S_D, S_MA, S_MW, S_F);
        add("rtype",  6'b000000, 1'b0, 4, S_F, S_D, S_EX, S_AWB, S_F);
        add("beq_z1", 6'b000100, 1'b1, 3, S_F, S_D, S_BR1, S_F, S_F);
        add("beq_z0", 6'b000100, 1'b0, 3, S_F, S_D, S_BR0, S_F, S_F);
        add("j",      6'b000010, 1'b0, 3, S_F, S_D, S_J, S_F, S_F);
        add("ill3f",  6'b111111, 1'b0, 2, S_F, S_DILL, S_F, S_F, S_F);
        add("ill01",  6'b000001, 1'b1, 2, S_F, S_DILL, S_F, S_F, S_F);
`ifdef MULTICYCLE_ADDI_EN
        add("addi",   6'b001000, 1'b0, 4, S_F, S_D, S_AE, S_AW, S_F);
`else
        add("addi",   6'b001000, 1'b0, 2, S_F, S_DILL, S_F, S_F, S_F);
`endif

        // Reset held: FETCH outputs asynchronously, also across clock edges
        bus_if.opcode = 6'b100011;
        bus_if.zero   = 1'b0;
        rst_n = 1'b0;
        #2;
        check("reset_async", S_F);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", S_F);

        // Release away from the edge; that cycle is the FETCH cycle
        #3;
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            bus_if.opcode = vecs[k].op;
            bus_if.zero   = vecs[k].zero;
            for (int c = 0; c < vecs[k].len; c++) begin
                check($sformatf("%s_c%0d", vecs[k].name, c + 1), vecs[k].exp[c]);
                @(posedge clk);
                #1;
            end
            check($sformatf("%s_next_fetch", vecs[k].name), S_F);
        end

        // BEQ zero flag toggled inside the BRANCH cycle: pc_en follows it live
        bus_if.opcode = 6'b000100;
        bus_if.zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("beq_live_z0", S_BR0);
        bus_if.zero = 1'b1;
        #1;
        check("beq_live_z1", S_BR1);
        @(posedge clk);
        #1;

        // Reset pulsed mid-MEMRD: FETCH within the same cycle, no MEMWB write
        bus_if.opcode = 6'b100011;
        bus_if.zero   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_memrd_pre", S_MR);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_memrd_fetch", S_F);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_memrd_decode", S_D);
        @(posedge clk);
        #1;
        check("rst_mid_memrd_restart", S_MA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL be fixed constants from the shared package.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 opcode  in  6  instr[31:26] from the instruction register; stable from DECODE until the next FETCH.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 alu_op  out  2  to ALU decoder: 00 add, 01 sub, 10 use funct.
REQ-007 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-008 alu_src_b  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-009 pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, branch, pc_write  out  1 each  standard multicycle datapath controls.
REQ-011 pc_en  out  1  = pc_write | (branch & zero), combinational.
REQ-012 illegal_op  out  1  unrecognised opcode flag.

Function
REQ-013 The block SHALL be a Moore FSM; every output except pc_en and illegal_op SHALL depend on the state register only.
REQ-014 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-015 Opcodes SHALL be: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
REQ-016 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (LW/SW), EXECUTE (RTYPE), BRANCH (BEQ), ADDIEX (ADDI), JUMP (J), FETCH (other).
REQ-017 Further transitions SHALL be: MEMADR->MEMRD (LW) or MEMWR (SW); MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-018 Asserted outputs per state SHALL be (all unlisted = 0):
  - FETCH: alu_src_b=01, ir_write, pc_write.
  - DECODE: alu_src_b=11.
  - MEMADR: alu_src_a, alu_src_b=10.
  - MEMRD: iord.
  - MEMWB: mem_to_reg, reg_write.
  - MEMWR: iord, mem_write.
  - EXECUTE: alu_src_a, alu_op=10.
  - ALUWB: reg_dst, reg_write.
  - BRANCH: alu_src_a, alu_op=01, pc_src=01, branch.
  - ADDIEX: alu_src_a, alu_src_b=10.
  - ADDIWB: reg_write.
  - JUMP: pc_src=10, pc_write.
REQ-019 Instruction latency in cycles (FETCH inclusive) SHALL be: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 2.
REQ-020 illegal_op SHALL be 1 only in DECODE with an unrecognised opcode; the FSM SHALL then return to FETCH with no register or memory write.
REQ-021 In MEMADR an opcode that is neither LW nor SW SHALL be unreachable; the FSM SHALL fall to FETCH and all unused state encodings SHALL go to FETCH.

Reset
REQ-022 While rst_n=0 the state SHALL be FETCH asynchronously, so outputs equal FETCH values (alu_src_b=01, ir_write=1, pc_write=1, pc_en=1, rest 0).
REQ-023 Deassertion SHALL take effect at the next rising edge; the first DECODE follows one cycle later.
REQ-024 Reset asserted in any state SHALL abort the instruction and force FETCH immediately.

Configuration
REQ-025 Macro MULTICYCLE_ADDI_EN:
  - Defined: ADDI uses DECODE->ADDIEX->ADDIWB.
  - Undefined: ADDIEX/ADDIWB SHALL not exist and opcode 001000 SHALL be treated as illegal (REQ-020).

Structure
REQ-026 Package mips_pkg SHALL hold the state enum, opcode constants, alu_op encodings (shared with the ALU decoder), and alu_src_b/pc_src encodings.
REQ-027 One combinational sub-module, mc_ctrl_outdec (state -> control vector), SHALL be used; next-state logic and the state register SHALL stay in multicycle_ctrl.

Verification
REQ-028 Reset then LW (100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-029 SW (101011): mem_write=1 and iord=1 in cycle 4 only; reg_write never 1.
REQ-030 BEQ with zero=1 -> pc_en=1 in cycle 3 with pc_src=01; with zero=0 -> pc_en=0 in cycle 3.
REQ-031 RTYPE -> alu_op=10 in cycle 3, reg_dst=1 and reg_write=1 in cycle 4; J -> pc_src=10 and pc_write=1 in cycle 3.
REQ-032 Opcode 111111 -> illegal_op=1 in cycle 2, FETCH in cycle 3; ADDI with MULTICYCLE_ADDI_EN undefined -> same response.
REQ-033 rst_n pulsed low mid-MEMRD -> FETCH outputs within the same cycle, with no MEMWB write.
